mem_addr_reg: RTL and testbench
===============================

// Module: mem_addr_reg
// PURPOSE
//  16-bit memory address register driving mem.addr_in, sitting directly upstream of the memory stage.
//  Loaded from the 8-bit main bus either bytewise or via a two-cycle low-then-high sequencer.
//  The sequencer commits the full address atomically. Also supports inc/dec stepping with wrap
//  detection, and drives either address byte back onto the main bus.
// PARAMETERS
//  WIDTH_ADDR   16  address width; must equal 2*WIDTH
//  WIDTH        8   main bus width
//  RESET_VALUE  0   value of addr_out after reset
// PORTS
//  clk        in   1           system clock; all state changes on posedge
//  reset      in   1           synchronous, active-high reset
//  main_in    in   WIDTH       main bus data in
//  load_lo    in   1           write main_in into addr[7:0]
//  load_hi    in   1           write main_in into addr[15:8]
//  load_seq   in   1           sequenced load: 1st strobe = low byte, 2nd = high byte
//  inc        in   1           addr <= addr + 1
//  dec        in   1           addr <= addr - 1
//  assert_lo  in   1           active-low: drive addr[7:0] onto main_out
//  assert_hi  in   1           active-low: drive addr[15:8] onto main_out
//  addr_out   out  WIDTH_ADDR  registered address to mem.addr_in
//  main_out   out  WIDTH       selected address byte (combinational)
//  main_en    out  1           main bus drive enable (combinational)
//  seq_busy   out  1           high while sequencer holds a low byte awaiting the high byte
//  wrap       out  1           one-cycle pulse: inc from all-ones or dec from zero
// BEHAVIOUR
//  - Reset (sync, wins over everything): addr_out=RESET_VALUE, shadow=0, state=IDLE,
//    seq_busy=0, wrap=0.
//  - Sequencer states:
//    - IDLE --load_seq--> WAIT_HI: shadow<=main_in; addr_out unchanged.
//    - WAIT_HI --load_seq--> IDLE: addr_out<={main_in,shadow} in one edge.
//  - seq_busy = (state==WAIT_HI), registered.
//  - Priority per edge: reset > load_seq > load_lo/load_hi > inc/dec.
//  - load_lo and load_hi together: both bytes <= main_in. Either direct load aborts WAIT_HI
//    (state->IDLE; shadow discarded).
//  - load_seq together with load_lo/load_hi: load_seq wins; direct loads are ignored.
//  - inc and dec: modulo 2^WIDTH_ADDR.
//    - Both high, or either with any load: no step, wrap=0.
//  - inc/dec in WAIT_HI: step the current addr_out; the sequence stays pending.
//    - The later commit overwrites the stepped value.
//  - wrap is registered; high only for the cycle after the wrapping edge.
//  - Latency: addr_out is valid the cycle after the load/step edge. No bypass from main_in.
//  - main_en = !assert_lo | !assert_hi.
//  - main_out: low byte if !assert_lo, else high byte if !assert_hi, else 0.
//    Both asserted -> low byte.
//  - The sequence is only terminated by reset or a direct load; no timeout.
// CONFIGURATION
//  MAR_AUTOINC_EN defined:
//   - Adds input access_done (1 bit). It increments addr_out exactly like inc, with the same
//     priority and wrap rules.
//   - access_done OR inc counts as a single increment.
//   - access_done together with dec counts as inc and dec both high: no step.
//   - Intended for the memory stage to pulse after each completed access, for block moves.
//  MAR_AUTOINC_EN undefined: port absent; addr changes only via loads, inc, dec.
// TESTING
//  - reset=1 for 1 edge -> addr_out=RESET_VALUE, seq_busy=0, wrap=0, main_en=0 (asserts high).
//  - load_seq with 0x34, then load_seq with 0x12 -> after 1st edge addr_out unchanged,
//    seq_busy=1; after 2nd edge addr_out=0x1234, seq_busy=0.
//  - addr=0xFFFF, inc 1 cycle -> addr=0x0000, wrap=1 for one cycle.
//    dec from 0x0000 -> 0xFFFF, wrap=1.
//  - load_seq 0xAA, then load_hi with 0x55 -> addr[15:8]=0x55, seq_busy=0, low byte unchanged.
//    A further load_seq 0x11 restarts at the low byte.
//  - addr=0xBEEF: assert_lo=0 -> main_out=0xEF, main_en=1; assert_hi=0 only -> 0xBE;
//    both=0 -> 0xEF.
//  - MAR_AUTOINC_EN: addr=0x00FE, access_done pulses on 3 cycles -> 0x0101.
//    access_done with dec -> no change.

Source files
------------

// File: rtl/mem_addr_reg.sv
// Memory address register: bytewise / sequenced loads from the main bus, inc/dec stepping
// with wrap pulse, and byte readback. Optional auto-increment input under MAR_AUTOINC_EN.
module mem_addr_reg #(
  parameter int unsigned           WIDTH_ADDR  = 16,
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH_ADDR-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      main_in,
  input  logic                  load_lo,
  input  logic                  load_hi,
  input  logic                  load_seq,
  input  logic                  inc,
  input  logic                  dec,
`ifdef MAR_AUTOINC_EN
  input  logic                  access_done,
`endif
  input  logic                  assert_lo,
  input  logic                  assert_hi,
  output logic [WIDTH_ADDR-1:0] addr_out,
  output logic [WIDTH-1:0]      main_out,
  output logic                  main_en,
  output logic                  seq_busy,
  output logic                  wrap
);

  if (WIDTH_ADDR != 2 * WIDTH) begin : g_width_check
    $error("mem_addr_reg: WIDTH_ADDR must equal 2*WIDTH");
  end

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_HI = 1'b1
  } state_e;

  state_e                state;
  state_e                state_nxt;
  logic [WIDTH-1:0]      shadow;
  logic [WIDTH-1:0]      shadow_nxt;
  logic [WIDTH_ADDR-1:0] addr_nxt;
  logic                  wrap_nxt;
  logic                  step_up;
  logic                  step_dn;
  logic                  direct_load;

`ifdef MAR_AUTOINC_EN
  assign step_up = inc | access_done;
`else
  assign step_up = inc;
`endif
  assign step_dn     = dec;
  assign direct_load = load_lo | load_hi;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequencer next state: load_seq toggles, a direct load aborts a pending sequence
  always_comb begin
    state_nxt = state;
    if (load_seq) begin
      state_nxt = (state == IDLE) ? WAIT_HI : IDLE;
    end else if (direct_load) begin
      state_nxt = IDLE;
    end
  end

  // Next address / shadow / wrap, by priority load_seq > direct load > step
  always_comb begin
    addr_nxt   = addr_out;
    shadow_nxt = shadow;
    wrap_nxt   = 1'b0;
    if (load_seq) begin
      if (state == IDLE) begin
        shadow_nxt = main_in;
      end else begin
        addr_nxt = WIDTH_ADDR'({main_in, shadow});
      end
    end else if (direct_load) begin
      if (load_lo) addr_nxt[WIDTH-1:0] = main_in;
      if (load_hi) addr_nxt[WIDTH_ADDR-1:WIDTH] = main_in;
    end else if (step_up && !step_dn) begin
      addr_nxt = addr_out + WIDTH_ADDR'(1);
      wrap_nxt = &addr_out;
    end else if (step_dn && !step_up) begin
      addr_nxt = addr_out - WIDTH_ADDR'(1);
      wrap_nxt = ~|addr_out;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_out <= RESET_VALUE;
      shadow   <= '0;
      wrap     <= 1'b0;
      seq_busy <= 1'b0;
    end else begin
      addr_out <= addr_nxt;
      shadow   <= shadow_nxt;
      wrap     <= wrap_nxt;
      seq_busy <= (state_nxt == WAIT_HI);
    end
  end

  // Bus readback; low byte wins when both are asserted
  always_comb begin
    main_en  = !assert_lo || !assert_hi;
    main_out = '0;
    if (!assert_lo) begin
      main_out = addr_out[WIDTH-1:0];
    end else if (!assert_hi) begin
      main_out = addr_out[WIDTH_ADDR-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_mem_addr_reg.sv
// Scoreboard bench for mem_addr_reg; exercises the auto-increment port when MAR_AUTOINC_EN is defined.
module tb_mem_addr_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  main_in;
  logic        load_lo, load_hi, load_seq, inc, dec;
  logic        access_done;
  logic        assert_lo, assert_hi;
  logic [15:0] addr_out;
  logic [7:0]  main_out;
  logic        main_en, seq_busy, wrap;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] addr;
    logic        busy;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];

  mem_addr_reg dut (
    .clk      (clk),
    .reset    (reset),
    .main_in  (main_in),
    .load_lo  (load_lo),
    .load_hi  (load_hi),
    .load_seq (load_seq),
    .inc      (inc),
    .dec      (dec),
`ifdef MAR_AUTOINC_EN
    .access_done (access_done),
`endif
    .assert_lo(assert_lo),
    .assert_hi(assert_hi),
    .addr_out (addr_out),
    .main_out (main_out),
    .main_en  (main_en),
    .seq_busy (seq_busy),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic clear_inputs();
    reset = 1'b0; main_in = 8'h00;
    load_lo = 1'b0; load_hi = 1'b0; load_seq = 1'b0;
    inc = 1'b0; dec = 1'b0; access_done = 1'b0;
    assert_lo = 1'b1; assert_hi = 1'b1;
  endtask

  // Push the expected post-edge state, clock once, then pop and compare
  task automatic cycle(input string tag, input logic [15:0] a, input logic b, input logic w);
    exp_t e;
    exp_q.push_back('{tag: tag, addr: a, busy: b, wrap: w});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({e.tag, ".addr"}, 32'(addr_out), 32'(e.addr));
    check_val({e.tag, ".busy"}, 32'(seq_busy), 32'(e.busy));
    check_val({e.tag, ".wrap"}, 32'(wrap), 32'(e.wrap));
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    cycle("reset", 16'h0000, 1'b0, 1'b0);
    check_val("reset.main_en", 32'(main_en), 32'd0);
    check_val("reset.main_out", 32'(main_out), 32'd0);

    // Sequenced load
    load_seq = 1'b1; main_in = 8'h34; cycle("seq_lo", 16'h0000, 1'b1, 1'b0);
    load_seq = 1'b1; main_in = 8'h12; cycle("seq_hi", 16'h1234, 1'b0, 1'b0);

    // Wrap on inc and dec
    load_lo = 1'b1; load_hi = 1'b1; main_in = 8'hFF; cycle("ld_both", 16'hFFFF, 1'b0, 1'b0);
    inc = 1'b1; cycle("inc_wrap", 16'h0000, 1'b0, 1'b1);
    cycle("wrap_clr", 16'h0000, 1'b0, 1'b0);
    dec = 1'b1; cycle("dec_wrap", 16'hFFFF, 1'b0, 1'b1);
    cycle("hold", 16'hFFFF, 1'b0, 1'b0);
    inc = 1'b1; dec = 1'b1; cycle("inc_dec", 16'hFFFF, 1'b0, 1'b0);
    inc = 1'b1; load_lo = 1'b1; main_in = 8'h00; cycle("inc_ld", 16'hFF00, 1'b0, 1'b0);

    // Abort and restart of the sequence
    load_seq = 1'b1; main_in = 8'hAA; cycle("seq_aa", 16'hFF00, 1'b1, 1'b0);
    load_hi = 1'b1; main_in = 8'h55; cycle("abort", 16'h5500, 1'b0, 1'b0);
    load_seq = 1'b1; main_in = 8'h11; cycle("restart", 16'h5500, 1'b1, 1'b0);
    inc = 1'b1; cycle("inc_pend", 16'h5501, 1'b1, 1'b0);
    load_seq = 1'b1; load_lo = 1'b1; main_in = 8'h22; cycle("seq_wins", 16'h2211, 1'b0, 1'b0);

    // Carry across byte boundary
    load_hi = 1'b1; main_in = 8'h00; cycle("ld_hi0", 16'h0011, 1'b0, 1'b0);
    load_lo = 1'b1; main_in = 8'hFF; cycle("ld_loff", 16'h00FF, 1'b0, 1'b0);
    inc = 1'b1; cycle("carry", 16'h0100, 1'b0, 1'b0);
    dec = 1'b1; cycle("borrow", 16'h00FF, 1'b0, 1'b0);

    // Bus readback
    load_hi = 1'b1; main_in = 8'hBE; cycle("ld_be", 16'hBEFF, 1'b0, 1'b0);
    load_lo = 1'b1; main_in = 8'hEF; cycle("ld_ef", 16'hBEEF, 1'b0, 1'b0);
    assert_lo = 1'b0; #1;
    check_val("rd_lo.data", 32'(main_out), 32'h00EF);
    check_val("rd_lo.en", 32'(main_en), 32'd1);
    assert_lo = 1'b1; assert_hi = 1'b0; #1;
    check_val("rd_hi.data", 32'(main_out), 32'h00BE);
    check_val("rd_hi.en", 32'(main_en), 32'd1);
    assert_lo = 1'b0; #1;
    check_val("rd_both.data", 32'(main_out), 32'h00EF);
    assert_lo = 1'b1; assert_hi = 1'b1; #1;
    check_val("rd_none.data", 32'(main_out), 32'h0000);
    check_val("rd_none.en", 32'(main_en), 32'd0);

    // Reset wins over a pending sequence commit
    load_seq = 1'b1; main_in = 8'h77; cycle("seq_77", 16'hBEEF, 1'b1, 1'b0);
    reset = 1'b1; load_seq = 1'b1; main_in = 8'h66; cycle("rst_mid", 16'h0000, 1'b0, 1'b0);
    load_seq = 1'b1; main_in = 8'h01; cycle("seq_post", 16'h0000, 1'b1, 1'b0);
    load_seq = 1'b1; main_in = 8'h02; cycle("seq_post2", 16'h0201, 1'b0, 1'b0);

`ifdef MAR_AUTOINC_EN
    load_lo = 1'b1; load_hi = 1'b1; main_in = 8'h00; cycle("ai_ld0", 16'h0000, 1'b0, 1'b0);
    load_lo = 1'b1; main_in = 8'hFE; cycle("ai_ldfe", 16'h00FE, 1'b0, 1'b0);
    access_done = 1'b1; cycle("ai_1", 16'h00FF, 1'b0, 1'b0);
    cycle("ai_gap", 16'h00FF, 1'b0, 1'b0);
    access_done = 1'b1; cycle("ai_2", 16'h0100, 1'b0, 1'b0);
    access_done = 1'b1; cycle("ai_3", 16'h0101, 1'b0, 1'b0);
    access_done = 1'b1; dec = 1'b1; cycle("ai_dec", 16'h0101, 1'b0, 1'b0);
    access_done = 1'b1; inc = 1'b1; cycle("ai_inc", 16'h0102, 1'b0, 1'b0);
`endif

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
